// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int          INST_W = 32;
  localparam logic [31:0] PC_INC = 32'd4;

  // One buffered fetch result: instruction word and the address it came from.
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [31:0]       pc;
  } fetch_entry_t;

  // Force an address onto a word boundary; the low two bits are ignored.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: DEPTH-entry circular FIFO with synchronous clear.
// Occupancy is tracked by the owner, which never pushes when full and never
// pops when empty, so the buffer keeps only its read/write pointers.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_push,
  input  fetch_entry_t i_push_data,
  input  logic         i_pop,
  output fetch_entry_t o_head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Data storage: written on push, no reset needed.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_clr) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointer update; a clear discards everything, including a same-cycle push/pop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
    end
  end

  assign o_head = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential word reads, buffers responses in
// order, and flushes on redirect while discarding responses still owed for
// requests issued before the redirect.
// Handshakes: a request transfers when o_imem_ren && i_imem_ready; a response
// is a single-cycle i_imem_valid pulse with no backpressure; an instruction
// transfers to decode when o_valid && i_ready.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0,
  parameter int          DEPTH      = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_imem_ready,
  output logic [31:0]       o_imem_raddr,
  output logic              o_imem_ren,
  input  logic              i_imem_valid,
  input  logic [INST_W-1:0] i_imem_rdata,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [INST_W-1:0] o_inst,
  output logic [31:0]       o_pc,
  input  logic              i_redirect,
  input  logic [31:0]       i_redirect_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  // Discard counter is wider than the buffer bound: redirects can stack up
  // stale requests faster than the memory returns them.
  localparam int DW = 16;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_count;
  logic [DW-1:0] r_drop;

  logic          w_accept;
  logic          w_resp_live;
  logic          w_resp_stale;
  logic          w_push;
  logic          w_pop;
  logic [CW:0]   w_occupancy;
  logic [31:0]   w_target;
  fetch_entry_t  w_push_data;
  fetch_entry_t  w_head;

  assign w_target     = align_pc(i_redirect_pc);
  assign w_occupancy  = {1'b0, r_inflight} + {1'b0, r_count};
  // Only request when a buffer slot is reserved for the answer.
  assign o_imem_ren   = i_rst_n && !i_redirect && (w_occupancy < (CW + 1)'(DEPTH));
  assign o_imem_raddr = r_fetch_pc;
  assign w_accept     = o_imem_ren && i_imem_ready;
  assign w_resp_stale = i_imem_valid && (r_drop != '0);
  assign w_resp_live  = i_imem_valid && (r_drop == '0);
  assign w_push       = w_resp_live && !i_redirect;
  assign o_valid      = (r_count != '0);
  assign w_pop        = o_valid && i_ready && !i_redirect;
  assign w_push_data  = '{inst: i_imem_rdata, pc: r_resp_pc};

  // Request/response address tracking; both restart at the redirect target.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fetch_pc <= RESET_ADDR;
      r_resp_pc  <= RESET_ADDR;
    end else if (i_redirect) begin
      r_fetch_pc <= w_target;
      r_resp_pc  <= w_target;
    end else begin
      if (w_accept) r_fetch_pc <= r_fetch_pc + PC_INC;
      if (w_push)   r_resp_pc  <= r_resp_pc + PC_INC;
    end
  end

  // Occupancy counters; on redirect every outstanding request becomes one to
  // discard, less any response that lands in the redirect cycle itself.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_inflight <= '0;
      r_count    <= '0;
      r_drop     <= '0;
    end else if (i_redirect) begin
      r_inflight <= '0;
      r_count    <= '0;
      r_drop     <= r_drop + DW'(r_inflight) - DW'(i_imem_valid);
    end else begin
      r_inflight <= r_inflight + CW'(w_accept) - CW'(w_resp_live);
      r_count    <= r_count + CW'(w_push) - CW'(w_pop);
      r_drop     <= r_drop - DW'(w_resp_stale);
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clr       (i_redirect),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_head)
  );

  assign o_inst = o_valid ? w_head.inst : '0;
  assign o_pc   = o_valid ? w_head.pc   : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model with fixed latency and issue interval,
// expected instruction stream derived from the last restart address.
module tb_fetch_unit;

  localparam logic [31:0] RESET_ADDR = 32'h0;
  localparam int          DEPTH      = 4;
  localparam int          LATENCY    = 4;
  localparam int          INTERVAL   = 2;
  localparam int          MEM_WORDS  = 1024;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_imem_ready;
  logic [31:0] o_imem_raddr;
  logic        o_imem_ren;
  logic        i_imem_valid;
  logic [31:0] i_imem_rdata;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_inst;
  logic [31:0] o_pc;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;

  fetch_unit #(.RESET_ADDR(RESET_ADDR), .DEPTH(DEPTH)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_imem_ready  (i_imem_ready),
    .o_imem_raddr  (o_imem_raddr),
    .o_imem_ren    (o_imem_ren),
    .i_imem_valid  (i_imem_valid),
    .i_imem_rdata  (i_imem_rdata),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_inst        (o_inst),
    .o_pc          (o_pc),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end
  always @(posedge i_clk) cyc <= cyc + 1;

  // ---------------- shared state ----------------
  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] mem [MEM_WORDS];
  logic [63:0] exp_q [$];       // {inst, pc} in required output order
  logic [31:0] acc_addr_q [$];  // addresses of accepted requests
  int acc_total     = 0;
  int first_acc_cyc = 0;
  logic mem_gate    = 1'b1;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } mreq_t;
  mreq_t pend [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // Expected stream after a restart: consecutive words from the aligned target.
  task automatic exp_fill(input logic [31:0] pc);
    logic [31:0] p;
    logic [9:0]  idx;
    exp_q.delete();
    p = {pc[31:2], 2'b00};
    for (int i = 0; i < 256; i++) begin
      idx = p[11:2];
      exp_q.push_back({mem[idx], p});
      p = p + 32'd4;
    end
  endtask

  // ---------------- memory model ----------------
  initial begin
    int          since_acc;
    logic [31:0] a;
    logic [9:0]  idx;
    i_imem_ready = 1'b1;
    i_imem_valid = 1'b0;
    i_imem_rdata = '0;
    since_acc    = INTERVAL;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        pend.delete();
      end else if (o_imem_ren && i_imem_ready) begin
        pend.push_back('{due: cyc + LATENCY, addr: o_imem_raddr});
        acc_addr_q.push_back(o_imem_raddr);
        if (acc_total == 0) first_acc_cyc = cyc + 1;
        acc_total++;
        since_acc = 0;
      end
      @(posedge i_clk);
      #1;
      if (!i_rst_n) begin
        pend.delete();
        since_acc    = INTERVAL;
        i_imem_valid = 1'b0;
      end else begin
        if (since_acc < INTERVAL) since_acc++;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
          a            = pend[0].addr;
          idx          = a[11:2];
          i_imem_valid = 1'b1;
          i_imem_rdata = mem[idx];
          void'(pend.pop_front());
        end else begin
          i_imem_valid = 1'b0;
        end
      end
      i_imem_ready = (since_acc >= INTERVAL) && mem_gate;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [63:0] e;
    int          acc_since;
    int          pop_since;
    logic        prev_hold;
    logic [31:0] prev_addr;
    acc_since = 0;
    pop_since = 0;
    prev_hold = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n || i_redirect) begin
        acc_since = 0;
        pop_since = 0;
        prev_hold = 1'b0;
      end else begin
        if (o_valid && i_ready) begin
          if (exp_q.size() == 0) begin
            fail_now("out_underflow");
          end else begin
            e = exp_q.pop_front();
            check("out_pc", {32'h0, o_pc}, {32'h0, e[31:0]});
            check("out_inst", {32'h0, o_inst}, {32'h0, e[63:32]});
          end
          pop_since++;
        end
        if (o_imem_ren) begin
          check("raddr_align", {62'h0, o_imem_raddr[1:0]}, 64'h0);
          if (prev_hold) check("raddr_stable", {32'h0, o_imem_raddr}, {32'h0, prev_addr});
          if (i_imem_ready) acc_since++;
        end
        check("occupancy_bound", {63'h0, (acc_since - pop_since) <= DEPTH}, 64'h1);
        prev_hold = o_imem_ren && !i_imem_ready;
        prev_addr = o_imem_raddr;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge i_clk);
    #3;
    i_rst_n    = 1'b0;
    i_redirect = 1'b0;
    #1;
    check("rst_async_ren", {63'h0, o_imem_ren}, 64'h0);
    check("rst_async_valid", {63'h0, o_valid}, 64'h0);
    repeat (3) @(posedge i_clk);
    #3;
    check("rst_raddr", {32'h0, o_imem_raddr}, {32'h0, RESET_ADDR});
    check("rst_inst", {32'h0, o_inst}, 64'h0);
    check("rst_pc", {32'h0, o_pc}, 64'h0);
    exp_fill(RESET_ADDR);
    acc_total = 0;
    acc_addr_q.delete();
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    @(posedge i_clk);
    #1;
    i_redirect    = 1'b1;
    i_redirect_pc = pc;
    exp_fill(pc);
    @(posedge i_clk);
    #1;
    i_redirect = 1'b0;
  endtask

  task automatic wait_acc(input int n, input string name);
    int t;
    t = 0;
    while (acc_total < n && t < 40) begin
      @(negedge i_clk);
      t++;
    end
    if (acc_total < n) fail_now(name);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t;
    i_rst_n       = 1'b0;
    i_ready       = 1'b1;
    i_redirect    = 1'b0;
    i_redirect_pc = '0;
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
    mem[0] = 32'h13;
    mem[1] = 32'h93;
    mem[2] = 32'h113;
    mem[3] = 32'h6F;

    // Reset release: first request immediately, in-order stream from 0.
    do_reset();
    @(negedge i_clk);
    check("first_req_ren", {63'h0, o_imem_ren}, 64'h1);
    check("first_req_addr", {32'h0, o_imem_raddr}, {32'h0, RESET_ADDR});
    t = 0;
    while (!o_valid && t < 30) begin
      @(negedge i_clk);
      t++;
    end
    if (!o_valid) fail_now("first_valid");
    else check("first_valid_latency", {63'h0, (cyc + 1 - first_acc_cyc) >= 5}, 64'h1);
    step(12);

    // Decode stall: buffer fills to exactly DEPTH, then drains one per cycle.
    i_ready = 1'b0;
    do_reset();
    step(40);
    check("stall_accepts", acc_total, DEPTH);
    @(negedge i_clk);
    check("stall_valid", {63'h0, o_valid}, 64'h1);
    check("stall_head_pc", {32'h0, o_pc}, 64'h0);
    @(posedge i_clk);
    #1;
    i_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge i_clk);
      check("drain_valid", {63'h0, o_valid}, 64'h1);
    end
    wait_acc(DEPTH + 1, "resume_accept");
    if (acc_addr_q.size() > DEPTH) check("resume_addr", {32'h0, acc_addr_q[DEPTH]}, 64'h10);
    step(10);

    // Redirect with two requests in flight.
    do_reset();
    wait_acc(2, "two_inflight");
    do_redirect(32'h100);
    step(20);

    // Redirect in a response cycle, then again the next cycle.
    t = 0;
    do begin
      @(posedge i_clk);
      #2;
      t++;
    end while (!i_imem_valid && t < 40);
    if (!i_imem_valid) fail_now("resp_cycle");
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h200;
    exp_fill(32'h200);
    @(posedge i_clk);
    #1;
    i_redirect_pc = 32'h300;
    exp_fill(32'h300);
    @(posedge i_clk);
    #1;
    i_redirect = 1'b0;
    step(20);

    // Unaligned target, then reset while fetching.
    do_redirect(32'h102);
    step(12);
    do_reset();
    wait_acc(1, "post_reset_accept");
    if (acc_addr_q.size() > 0) check("post_reset_addr", {32'h0, acc_addr_q[0]}, {32'h0, RESET_ADDR});
    step(15);

    // Address wrap at the top of the space.
    do_redirect(32'hFFFF_FFF6);
    step(25);

    // Randomized traffic: decode stalls, memory stalls, redirects.
    for (int n = 0; n < 600; n++) begin
      @(posedge i_clk);
      #1;
      i_ready  = ($urandom_range(0, 3) != 0);
      mem_gate = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 24) == 0) begin
        i_redirect    = 1'b1;
        i_redirect_pc = $urandom_range(0, 32'h1FFF);
        exp_fill(i_redirect_pc);
      end else begin
        i_redirect = 1'b0;
      end
    end
    @(posedge i_clk);
    #1;
    i_redirect = 1'b0;
    i_ready    = 1'b1;
    mem_gate   = 1'b1;
    step(30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
